lc3_control_fsm: RTL and testbench
==================================

Name: lc3_control_fsm

Overview:
Multicycle control unit for the LC-3 datapath. It drives the ALU's aluControl and the datapath load, gate and mux selects from the IR contents, condition codes and a memory ready handshake. It sequences fetch, decode and execute for ADD, AND, NOT, BR, JMP, LEA, LD, LDR, ST and STR. It sits between the IR/CC registers and the datapath, which contains the ALU and the register file.

Parameters:
HALT_ON_ILLEGAL, 0, 1 = an unsupported opcode parks the FSM in HALT until reset; 0 = skip the instruction and return to F1.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
ir  in  16  current IR contents
n, z, p  in  1 each  condition-code register bits
mem_ready  in  1  memory completes the current access this cycle
ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc  out  1 each  register load enables
gate_pc, gate_alu, gate_mdr, gate_marmux  out  1 each  bus drivers; at most one high per cycle
pcmux  out  2  00 PC+1, 01 bus, 10 address adder
addr1mux  out  1  0 PC, 1 SR1
addr2mux  out  2  00 zero, 01 sext(IR[5:0]), 10 sext(IR[8:0]), 11 sext(IR[10:0])
marmux  out  1  1 address adder (always 1 when gate_marmux is high)
mdr_sel  out  1  0 bus, 1 memory data
aluControl  out  2  00 pass A, 01 ADD, 10 AND, 11 NOT A
dr, sr1  out  3 each  register file selects
mem_en, mem_we  out  1 each  memory request and write
illegal_op  out  1  one-cycle pulse in DEC on an unsupported opcode
halted  out  1  high while in HALT

Behaviour:
- Reset (async, rst_n=0): state=F1 immediately. Every output is 0 except sr1=0, dr=0 and the selects, which are all 0. A reset mid-access drops mem_en the same instant.
- All outputs are Moore (decoded from state and ir), except ld_mdr in the read-wait states, which is qualified by mem_ready.
- In every state, any enable or select not listed below is 0.
- F1: gate_pc, ld_mar, ld_pc, pcmux=00. Next state F2.
- F2: mem_en=1, mdr_sel=1, ld_mdr=mem_ready. Stay in F2 while !mem_ready; when mem_ready, go to F3.
- F3: gate_mdr, ld_ir. Next state DEC.
- DEC: no loads. Branch on ir[15:12]:
  - 0001 and 0101 → ALU
  - 1001 → ALU
  - 0000 → BR
  - 1100 → JMP
  - 1110 → LEA
  - 0010 and 0011 → MA_PC
  - 0110 and 0111 → MA_BASE
  - anything else → illegal_op=1, then HALT if HALT_ON_ILLEGAL, else F1.
- ALU: gate_alu, ld_reg, ld_cc, dr=ir[11:9], sr1=ir[8:6]. aluControl is 01 for opcode 0001, 10 for 0101, 11 for 1001. Next state F1. The ir[5] immediate select lives in the ALU, not here.
- BR: if (ir[11]&n)|(ir[10]&z)|(ir[9]&p), assert ld_pc with pcmux=10, addr1mux=0, addr2mux=10. Otherwise no load. Next state F1. ir[11:9]=000 never branches.
- JMP: ld_pc, pcmux=10, addr1mux=1, addr2mux=00, sr1=ir[8:6]. Next state F1.
- LEA: gate_marmux, marmux=1, addr1mux=0, addr2mux=10, ld_reg, ld_cc, dr=ir[11:9]. Next state F1.
- MA_PC: gate_marmux, ld_mar, addr1mux=0, addr2mux=10.
- MA_BASE: gate_marmux, ld_mar, addr1mux=1, addr2mux=01, sr1=ir[8:6].
- From MA_PC or MA_BASE: go to RD if ir[12]=0 (loads), or SD if ir[12]=1 (stores).
- RD: mem_en, mdr_sel=1, ld_mdr=mem_ready. Wait for mem_ready, then go to WB.
- WB: gate_mdr, ld_reg, ld_cc, dr=ir[11:9]. Next state F1.
- SD: gate_alu, aluControl=00, sr1=ir[11:9], mdr_sel=0, ld_mdr. Next state WR.
- WR: mem_en, mem_we. Hold until mem_ready, then go to F1.
- Memory handshake: mem_en and mem_we stay stable from request until the mem_ready cycle. mem_ready outside F2, RD and WR is ignored.
- HALT: all enables 0, halted=1. Only rst_n exits.
- Latency: ALU, BR, JMP and LEA take 5 cycles with mem_ready tied 1. LD/LDR take 7 cycles, ST/STR take 7 cycles. Each wait cycle adds 1.
- A single-cycle bus-driver check is enforced by an assertion in the bench.

Test Plan:
- mem_ready=1, ir=0x1283 (ADD R1,R2,R3) → sequence F1,F2,F3,DEC,ALU. In ALU: aluControl=01, dr=1, sr1=2, ld_reg=ld_cc=gate_alu=1. Back in F1 on cycle 6.
- ir=0x0402 (BRz), z=1 → BR asserts ld_pc, pcmux=10, addr2mux=10. Repeat with z=0 → ld_pc=0 in BR.
- ir=0x2205 (LD R1), mem_ready low for 3 cycles in RD → RD held 4 cycles, ld_mdr only on the last. Then WB with gate_mdr=1, dr=1.
- ir=0x7A41 (STR R5,R1,#1) → MA_BASE with addr2mux=01, sr1=1. SD with sr1=5, aluControl=00, mdr_sel=0. WR keeps mem_we=1 until mem_ready.
- ir=0xD000, HALT_ON_ILLEGAL=1 → illegal_op pulses in DEC, halted=1 and stays. With the parameter at 0 → returns to F1.
- rst_n low during WR wait → mem_en and mem_we fall without a clock edge. After release, first state is F1.

Source files
------------

// File: rtl/lc3_control_fsm.sv
// LC-3 multicycle control unit: fetch/decode/execute sequencing that drives
// datapath loads, bus gates, mux selects, ALU op and memory handshake.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ir, n/z/p           instruction register and condition codes
//   mem_ready           memory completes the current access
//   ld_*, gate_*        register loads and bus drivers
//   pcmux..mdr_sel      datapath mux selects
//   aluControl, dr, sr1 ALU op and register file selects
//   mem_en, mem_we      memory request and write
//   illegal_op, halted  unsupported-opcode pulse and halt status
module lc3_control_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_ready,
  output logic        ld_pc,
  output logic        ld_ir,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_reg,
  output logic        ld_cc,
  output logic        gate_pc,
  output logic        gate_alu,
  output logic        gate_mdr,
  output logic        gate_marmux,
  output logic [1:0]  pcmux,
  output logic        addr1mux,
  output logic [1:0]  addr2mux,
  output logic        marmux,
  output logic        mdr_sel,
  output logic [1:0]  aluControl,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic        mem_en,
  output logic        mem_we,
  output logic        illegal_op,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_F1, S_F2, S_F3, S_DEC,
    S_ALU, S_BR, S_JMP, S_LEA,
    S_MA_PC, S_MA_BASE, S_RD, S_WB,
    S_SD, S_WR, S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [3:0] op;
  logic       br_taken;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign br_taken  = |(ir[11:9] & {n, z, p});
  // Immediate/offset fields are consumed by the datapath, not here.
  assign unused_ir = ^ir[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_F1;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_F1: state_d = S_F2;
      S_F2: state_d = mem_ready ? S_F3 : S_F2;
      S_F3: state_d = S_DEC;
      S_DEC: begin
        case (op)
          4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
          4'b0000: state_d = S_BR;
          4'b1100: state_d = S_JMP;
          4'b1110: state_d = S_LEA;
          4'b0010, 4'b0011: state_d = S_MA_PC;
          4'b0110, 4'b0111: state_d = S_MA_BASE;
          default: state_d = HALT_ON_ILLEGAL ? S_HALT : S_F1;
        endcase
      end
      S_ALU, S_BR, S_JMP, S_LEA, S_WB: state_d = S_F1;
      // ir[12] separates stores (ST/STR) from loads (LD/LDR).
      S_MA_PC, S_MA_BASE: state_d = ir[12] ? S_SD : S_RD;
      S_RD: state_d = mem_ready ? S_WB : S_RD;
      S_SD: state_d = S_WR;
      S_WR: state_d = mem_ready ? S_F1 : S_WR;
      S_HALT: state_d = S_HALT;
      default: state_d = S_F1;
    endcase
  end

  always_comb begin
    ld_pc       = 1'b0;
    ld_ir       = 1'b0;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_reg      = 1'b0;
    ld_cc       = 1'b0;
    gate_pc     = 1'b0;
    gate_alu    = 1'b0;
    gate_mdr    = 1'b0;
    gate_marmux = 1'b0;
    pcmux       = 2'b00;
    addr1mux    = 1'b0;
    addr2mux    = 2'b00;
    marmux      = 1'b0;
    mdr_sel     = 1'b0;
    aluControl  = 2'b00;
    dr          = 3'd0;
    sr1         = 3'd0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    // Outputs are forced low while reset is held so an in-flight memory
    // request drops immediately rather than at the next edge.
    if (rst_n) begin
      case (state_q)
        S_F1: begin
          gate_pc = 1'b1;
          ld_mar  = 1'b1;
          ld_pc   = 1'b1;
        end
        S_F2, S_RD: begin
          mem_en  = 1'b1;
          mdr_sel = 1'b1;
          ld_mdr  = mem_ready;
        end
        S_F3: begin
          gate_mdr = 1'b1;
          ld_ir    = 1'b1;
        end
        S_DEC: begin
          case (op)
            4'b0001, 4'b0101, 4'b1001,
            4'b0000, 4'b1100, 4'b1110,
            4'b0010, 4'b0011,
            4'b0110, 4'b0111: illegal_op = 1'b0;
            default:          illegal_op = 1'b1;
          endcase
        end
        S_ALU: begin
          gate_alu = 1'b1;
          ld_reg   = 1'b1;
          ld_cc    = 1'b1;
          dr       = ir[11:9];
          sr1      = ir[8:6];
          case (op)
            4'b0101: aluControl = 2'b10;
            4'b1001: aluControl = 2'b11;
            default: aluControl = 2'b01;
          endcase
        end
        S_BR: begin
          if (br_taken) begin
            ld_pc    = 1'b1;
            pcmux    = 2'b10;
            addr2mux = 2'b10;
          end
        end
        S_JMP: begin
          ld_pc    = 1'b1;
          pcmux    = 2'b10;
          addr1mux = 1'b1;
          sr1      = ir[8:6];
        end
        S_LEA: begin
          gate_marmux = 1'b1;
          marmux      = 1'b1;
          addr2mux    = 2'b10;
          ld_reg      = 1'b1;
          ld_cc       = 1'b1;
          dr          = ir[11:9];
        end
        S_MA_PC: begin
          gate_marmux = 1'b1;
          marmux      = 1'b1;
          ld_mar      = 1'b1;
          addr2mux    = 2'b10;
        end
        S_MA_BASE: begin
          gate_marmux = 1'b1;
          marmux      = 1'b1;
          ld_mar      = 1'b1;
          addr1mux    = 1'b1;
          addr2mux    = 2'b01;
          sr1         = ir[8:6];
        end
        S_WB: begin
          gate_mdr = 1'b1;
          ld_reg   = 1'b1;
          ld_cc    = 1'b1;
          dr       = ir[11:9];
        end
        // Store data reaches MDR by passing SR through the ALU.
        S_SD: begin
          gate_alu = 1'b1;
          sr1      = ir[11:9];
          ld_mdr   = 1'b1;
        end
        S_WR: begin
          mem_en = 1'b1;
          mem_we = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Randomized bench for lc3_control_fsm against a phase-list reference model.
// Checks every cycle's full output vector, plus halt and async-reset cases.
module tb_lc3_control_fsm;

  typedef struct packed {
    logic       ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc;
    logic       gate_pc, gate_alu, gate_mdr, gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux, mdr_sel;
    logic [1:0] alu;
    logic [2:0] dr, sr1;
    logic       mem_en, mem_we, illegal_op, halted;
  } out_t;

  typedef enum {
    P_F1, P_F2, P_F3, P_DEC, P_ALU, P_BR, P_JMP, P_LEA,
    P_MA_PC, P_MA_BASE, P_RD, P_WB, P_SD, P_WR, P_HALT
  } ph_e;

  logic        clk = 1'b0;
  logic        rst_n, rst_h;
  logic [15:0] ir, ir_h;
  logic        n, z, p;
  logic        mem_ready, mem_ready_h;
  wire  [28:0] mv, hv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lc3_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .n(n), .z(z), .p(p),
    .mem_ready(mem_ready),
    .ld_pc(mv[28]), .ld_ir(mv[27]), .ld_mar(mv[26]),
    .ld_mdr(mv[25]), .ld_reg(mv[24]), .ld_cc(mv[23]),
    .gate_pc(mv[22]), .gate_alu(mv[21]), .gate_mdr(mv[20]),
    .gate_marmux(mv[19]), .pcmux(mv[18:17]), .addr1mux(mv[16]),
    .addr2mux(mv[15:14]), .marmux(mv[13]), .mdr_sel(mv[12]),
    .aluControl(mv[11:10]), .dr(mv[9:7]), .sr1(mv[6:4]),
    .mem_en(mv[3]), .mem_we(mv[2]),
    .illegal_op(mv[1]), .halted(mv[0])
  );

  lc3_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) u_halt (
    .clk(clk), .rst_n(rst_h), .ir(ir_h), .n(n), .z(z), .p(p),
    .mem_ready(mem_ready_h),
    .ld_pc(hv[28]), .ld_ir(hv[27]), .ld_mar(hv[26]),
    .ld_mdr(hv[25]), .ld_reg(hv[24]), .ld_cc(hv[23]),
    .gate_pc(hv[22]), .gate_alu(hv[21]), .gate_mdr(hv[20]),
    .gate_marmux(hv[19]), .pcmux(hv[18:17]), .addr1mux(hv[16]),
    .addr2mux(hv[15:14]), .marmux(hv[13]), .mdr_sel(hv[12]),
    .aluControl(hv[11:10]), .dr(hv[9:7]), .sr1(hv[6:4]),
    .mem_en(hv[3]), .mem_we(hv[2]),
    .illegal_op(hv[1]), .halted(hv[0])
  );

  always @(negedge clk) begin
    assert ($countones(mv[22:19]) <= 1)
      else $error("bus contention main %b", mv[22:19]);
    assert ($countones(hv[22:19]) <= 1)
      else $error("bus contention halt %b", hv[22:19]);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'hE,
                      4'h2, 4'h3, 4'h6, 4'h7};
  endfunction

  // Expected outputs for one cycle spent in phase ph.
  function automatic out_t model(input ph_e ph, input logic [15:0] i,
                                 input logic [2:0] cc, input logic rdy);
    out_t e;
    e = '0;
    case (ph)
      P_F1: begin e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1; end
      P_F2, P_RD: begin e.mem_en = 1; e.mdr_sel = 1; e.ld_mdr = rdy; end
      P_F3: begin e.gate_mdr = 1; e.ld_ir = 1; end
      P_DEC: e.illegal_op = !legal(i[15:12]);
      P_ALU: begin
        e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1;
        e.dr = i[11:9]; e.sr1 = i[8:6];
        e.alu = (i[15:12] == 4'h1) ? 2'd1 :
                (i[15:12] == 4'h5) ? 2'd2 : 2'd3;
      end
      P_BR: if ((i[11:9] & cc) != 3'b000) begin
        e.ld_pc = 1; e.pcmux = 2'b10; e.addr2mux = 2'b10;
      end
      P_JMP: begin
        e.ld_pc = 1; e.pcmux = 2'b10; e.addr1mux = 1; e.sr1 = i[8:6];
      end
      P_LEA: begin
        e.gate_marmux = 1; e.marmux = 1; e.addr2mux = 2'b10;
        e.ld_reg = 1; e.ld_cc = 1; e.dr = i[11:9];
      end
      P_MA_PC: begin
        e.gate_marmux = 1; e.marmux = 1; e.ld_mar = 1;
        e.addr2mux = 2'b10;
      end
      P_MA_BASE: begin
        e.gate_marmux = 1; e.marmux = 1; e.ld_mar = 1;
        e.addr1mux = 1; e.addr2mux = 2'b01; e.sr1 = i[8:6];
      end
      P_WB: begin
        e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; e.dr = i[11:9];
      end
      P_SD: begin e.gate_alu = 1; e.sr1 = i[11:9]; e.ld_mdr = 1; end
      P_WR: begin e.mem_en = 1; e.mem_we = 1; end
      P_HALT: e.halted = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input ph_e ph, input logic [15:0] iv,
                      input logic [2:0] cc, input logic rdy);
    @(negedge clk);
    ir = iv;
    {n, z, p} = cc;
    mem_ready = rdy;
    #1;
    check(ph.name(), {3'b0, mv}, {3'b0, model(ph, iv, cc, rdy)});
  endtask

  // One instruction from F1 to its last phase; waits<0 means random stalls.
  task automatic run_instr(input logic [15:0] iv, input logic [2:0] cc,
                           input int waits);
    ph_e q[$];
    int  k;
    logic [3:0] op;
    op = iv[15:12];
    q = '{P_F1, P_F2, P_F3, P_DEC};
    case (op)
      4'h1, 4'h5, 4'h9: q.push_back(P_ALU);
      4'h0: q.push_back(P_BR);
      4'hC: q.push_back(P_JMP);
      4'hE: q.push_back(P_LEA);
      4'h2: q = {q, P_MA_PC, P_RD, P_WB};
      4'h3: q = {q, P_MA_PC, P_SD, P_WR};
      4'h6: q = {q, P_MA_BASE, P_RD, P_WB};
      4'h7: q = {q, P_MA_BASE, P_SD, P_WR};
      default: ;
    endcase
    foreach (q[j]) begin
      if (q[j] inside {P_F2, P_RD, P_WR}) begin
        k = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
        repeat (k) step(q[j], iv, cc, 1'b0);
        step(q[j], iv, cc, 1'b1);
      end else begin
        step(q[j], iv, cc, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] iv;
    ph_e hseq[7];
    rst_n = 1'b0;
    rst_h = 1'b0;
    ir = 16'h0;
    ir_h = 16'hD000;
    {n, z, p} = 3'b000;
    mem_ready = 1'b0;
    mem_ready_h = 1'b1;

    @(negedge clk);
    #1;
    check("reset_main", {3'b0, mv}, 32'h0);
    check("reset_halt", {3'b0, hv}, 32'h0);

    // Illegal opcode with halting enabled.
    #1 rst_h = 1'b1;
    hseq = '{P_F1, P_F2, P_F3, P_DEC, P_HALT, P_HALT, P_HALT};
    #1;
    foreach (hseq[j]) begin
      if (j > 0) begin
        @(negedge clk);
        #1;
      end
      check({"halt_", hseq[j].name()}, {3'b0, hv},
            {3'b0, model(hseq[j], 16'hD000, 3'b000, 1'b1)});
    end

    @(posedge clk);
    #2 rst_n = 1'b1;

    run_instr(16'h1283, 3'b000, 0);
    run_instr(16'h0402, 3'b010, 0);
    run_instr(16'h0402, 3'b101, 0);
    run_instr(16'h0E00 & 16'hF1FF, 3'b111, 0);
    run_instr(16'h2205, 3'b000, 3);
    run_instr(16'h7A41, 3'b000, 2);
    run_instr(16'hD000, 3'b000, 0);
    run_instr(16'h5A7F, 3'b000, 0);
    run_instr(16'h947F, 3'b000, 1);
    run_instr(16'hC1C0, 3'b000, 0);
    run_instr(16'hEC20, 3'b000, 0);
    run_instr(16'h6A81, 3'b000, 1);
    run_instr(16'h3610, 3'b000, 2);

    for (int t = 0; t < 150; t++) begin
      iv = 16'($urandom);
      run_instr(iv, 3'($urandom), -1);
    end

    // Reset asserted while a store waits for memory.
    iv = 16'h3A10;
    step(P_F1, iv, 3'b000, 1'b0);
    step(P_F2, iv, 3'b000, 1'b1);
    step(P_F3, iv, 3'b000, 1'b0);
    step(P_DEC, iv, 3'b000, 1'b0);
    step(P_MA_PC, iv, 3'b000, 1'b0);
    step(P_SD, iv, 3'b000, 1'b0);
    step(P_WR, iv, 3'b000, 1'b0);
    step(P_WR, iv, 3'b000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem", {30'b0, mv[3], mv[2]}, 32'h0);
    check("rst_all", {3'b0, mv}, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_instr(16'h1283, 3'b000, 0);
    run_instr(16'h2205, 3'b000, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
